// File: rtl/aead_job_ctrl.sv
// Job sequencer for a shared Ascon AEAD core (encrypt + decrypt pair).
// Ports: req_* job in, core_* core drive/observe, rsp_* result out, busy.
module aead_job_ctrl #(
  parameter int KEY_l   = 128,
  parameter int A_l     = 40,
  parameter int text_l  = 40,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [KEY_l-1:0]  req_key,
  input  logic [127:0]      req_nonce,
  input  logic [A_l-1:0]    req_assoc,
  input  logic [text_l-1:0] req_text,
  input  logic [127:0]      req_tag,
  output logic [KEY_l-1:0]  core_key,
  output logic [127:0]      core_nonce,
  output logic [A_l-1:0]    core_assoc,
  output logic [text_l-1:0] core_text,
  output logic              core_en_start,
  output logic              core_dec_start,
  input  logic              core_en_ready,
  input  logic              core_dec_ready,
  input  logic [text_l-1:0] core_ct,
  input  logic [127:0]      core_tag,
  input  logic [text_l-1:0] core_dec_pt,
  input  logic [127:0]      core_dec_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_op,
  output logic [text_l-1:0] rsp_text,
  output logic [127:0]      rsp_tag,
  output logic              rsp_auth,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP,
    RECOVER
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_op;
  logic [KEY_l-1:0]  r_key;
  logic [127:0]      r_nonce;
  logic [A_l-1:0]    r_assoc;
  logic [text_l-1:0] r_text;
  logic [127:0]      r_tag;
  logic [CW-1:0]     r_cnt;
  logic [text_l-1:0] r_rsp_text;
  logic [127:0]      r_rsp_tag;
  logic              r_rsp_auth;
  logic              r_rsp_to;

  logic w_sel_rdy;
  logic w_cnt_end;

  // Only the ready of the op in flight matters; the other is a stray.
  assign w_sel_rdy = r_op ? core_dec_ready : core_en_ready;
  assign w_cnt_end = (r_cnt == TO_C);

  always_comb begin
    w_next         = r_state;
    req_ready      = 1'b0;
    busy           = 1'b1;
    core_en_start  = 1'b0;
    core_dec_start = 1'b0;
    rsp_valid      = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = 1'b1;
        if (req_valid) w_next = RUN;
      end
      RUN: begin
        core_en_start  = ~r_op;
        core_dec_start = r_op;
        if (w_sel_rdy || w_cnt_end) w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = RECOVER;
      end
      RECOVER: begin
        // Wait for the core to drop both readies before a new start.
        if (!core_en_ready && !core_dec_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= 1'b0;
      r_key      <= '0;
      r_nonce    <= '0;
      r_assoc    <= '0;
      r_text     <= '0;
      r_tag      <= '0;
      r_cnt      <= '0;
      r_rsp_text <= '0;
      r_rsp_tag  <= '0;
      r_rsp_auth <= 1'b0;
      r_rsp_to   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_op    <= req_op;
        r_key   <= req_key;
        r_nonce <= req_nonce;
        r_assoc <= req_assoc;
        r_text  <= req_text;
        r_tag   <= req_tag;
        r_cnt   <= '0;
      end
      if (r_state == RUN) begin
        if (!w_cnt_end) r_cnt <= r_cnt + 1'b1;
        // Completion takes priority over a coincident timeout.
        if (w_sel_rdy) begin
          r_rsp_to <= 1'b0;
          if (r_op) begin
            r_rsp_text <= core_dec_pt;
            r_rsp_tag  <= core_dec_tag;
            r_rsp_auth <= (core_dec_tag == r_tag);
          end else begin
            r_rsp_text <= core_ct;
            r_rsp_tag  <= core_tag;
            r_rsp_auth <= 1'b0;
          end
        end else if (w_cnt_end) begin
          r_rsp_text <= '0;
          r_rsp_tag  <= '0;
          r_rsp_auth <= 1'b0;
          r_rsp_to   <= 1'b1;
        end
      end
    end
  end

  assign core_key    = r_key;
  assign core_nonce  = r_nonce;
  assign core_assoc  = r_assoc;
  assign core_text   = r_text;
  assign rsp_op      = r_op;
  assign rsp_text    = r_rsp_text;
  assign rsp_tag     = r_rsp_tag;
  assign rsp_auth    = r_rsp_auth;
  assign rsp_timeout = r_rsp_to;

endmodule
